// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder, one digit per clock, LSD first.
// Define BCD_ADDSUB_SUB_EN to enable nines-complement subtraction via the sub port.
module bcd_serial_addsub #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    input  logic                  sub,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err
);
    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic [IW-1:0]   idx;
    logic            carry;

    logic [3:0]      da;
    logic [3:0]      db;
    logic [3:0]      dbx;
    logic [4:0]      t;
    logic [3:0]      dsum;
    logic            cnext;
    logic            dbad;

`ifdef BCD_ADDSUB_SUB_EN
    logic            sub_r;
`else
    logic            unused_sub;
    assign unused_sub = sub;
`endif

    // One BCD digit step on the current least-significant operand digits
    always_comb begin
        da    = a_r[3:0];
        db    = b_r[3:0];
`ifdef BCD_ADDSUB_SUB_EN
        dbx   = sub_r ? 4'(4'd9 - db) : db;
`else
        dbx   = db;
`endif
        t     = {1'b0, da} + {1'b0, dbx} + {4'b0000, carry};
        dsum  = t[3:0];
        cnext = 1'b0;
        if (t > 5'd9) begin
            dsum  = 4'(t + 5'd6);
            cnext = 1'b1;
        end
        dbad  = (da > 4'd9) || (db > 4'd9);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            a_r   <= '0;
            b_r   <= '0;
            idx   <= '0;
            carry <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            err   <= 1'b0;
`ifdef BCD_ADDSUB_SUB_EN
            sub_r <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state <= S_RUN;
                        busy  <= 1'b1;
                        a_r   <= a;
                        b_r   <= b;
                        idx   <= '0;
                        err   <= 1'b0;
`ifdef BCD_ADDSUB_SUB_EN
                        sub_r <= sub;
                        carry <= sub ? ~cin : cin;
`else
                        carry <= cin;
`endif
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    sum[{idx, 2'b00} +: 4] <= dsum;
                    carry <= cnext;
                    err   <= err | dbad;
                    a_r   <= a_r >> 4;
                    b_r   <= b_r >> 4;
                    if (idx == IW'(DIGITS - 1)) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        cout  <= cnext;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Directed-vector bench for bcd_serial_addsub (DIGITS=4 main instance, DIGITS=1 side instance).
module tb_bcd_serial_addsub;
    localparam int unsigned DIGITS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a, b;
    logic        cin, sub;
    logic        busy, done, cout, err;
    logic [15:0] sum;

    logic        start1;
    logic [3:0]  a1, b1;
    logic        busy1, done1, cout1, err1;
    logic [3:0]  sum1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bcd_serial_addsub #(.DIGITS(DIGITS)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .err(err)
    );

    bcd_serial_addsub #(.DIGITS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(1'b0), .sub(1'b0),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .err(err1)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        co;
        logic        er;
    } vec_t;

    localparam int NV = 10;
    vec_t vt[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v, input string tag);
        int lat;
        @(negedge clk);
        a = v.a; b = v.b; cin = v.cin; sub = v.sub; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, ".busy_run"}, 32'(busy), 32'd1);
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'(DIGITS));
        check({tag, ".busy_done"}, 32'(busy), 32'd0);
        check({tag, ".sum"}, 32'(sum), 32'(v.s));
        check({tag, ".cout"}, 32'(cout), 32'(v.co));
        check({tag, ".err"}, 32'(err), 32'(v.er));
        @(posedge clk); #1;
        check({tag, ".done_pulse"}, 32'(done), 32'd0);
        check({tag, ".sum_hold"}, 32'(sum), 32'(v.s));
    endtask

    initial begin
        int lat, seen;

        vt[0] = '{16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0};
        vt[1] = '{16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[2] = '{16'h0999, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0};
        vt[3] = '{16'h000A, 16'h0001, 1'b0, 1'b0, 16'h0011, 1'b0, 1'b1};
        vt[4] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        vt[5] = '{16'h9999, 16'h9999, 1'b1, 1'b0, 16'h9999, 1'b1, 1'b0};
        vt[6] = '{16'h4321, 16'h1111, 1'b1, 1'b0, 16'h5433, 1'b0, 1'b0};
`ifdef BCD_ADDSUB_SUB_EN
        vt[7] = '{16'h5000, 16'h1234, 1'b0, 1'b1, 16'h3766, 1'b1, 1'b0};
        vt[8] = '{16'h1234, 16'h5000, 1'b0, 1'b1, 16'h6234, 1'b0, 1'b0};
        vt[9] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'h9999, 1'b0, 1'b0};
`else
        vt[7] = '{16'h5000, 16'h1234, 1'b0, 1'b1, 16'h6234, 1'b0, 1'b0};
        vt[8] = '{16'h1234, 16'h5000, 1'b0, 1'b1, 16'h6234, 1'b0, 1'b0};
        vt[9] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b0};
`endif

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        check("reset.sum", 32'(sum), 32'd0);
        check("reset.cout", 32'(cout), 32'd0);
        check("reset.err", 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++)
            run_op(vt[i], $sformatf("vec%0d", i));

        // Back-to-back: start held through RUN and DONE, operands disturbed mid-run
        @(negedge clk);
        a = 16'h1234; b = 16'h5678; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        a = 16'h9999; b = 16'h9999;
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("b2b.lat1", 32'(lat), 32'(DIGITS));
        check("b2b.sum1", 32'(sum), 32'h6912);
        a = 16'h0100; b = 16'h0200;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b.no_double_done", 32'(done), 32'd0);
        check("b2b.busy2", 32'(busy), 32'd1);
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("b2b.gap", 32'(lat + 1), 32'd5);
        check("b2b.sum2", 32'(sum), 32'h0300);
        check("b2b.cout2", 32'(cout), 32'd0);
        repeat (2) @(posedge clk);

        // Reset during RUN aborts with no done
        @(negedge clk);
        a = 16'h1234; b = 16'h5678; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.done", 32'(done), 32'd0);
        check("abort.sum", 32'(sum), 32'd0);
        check("abort.cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        check("abort.no_done", 32'(seen), 32'd0);
        run_op(vt[0], "after_abort");

        // DIGITS=1 instance: 7+5 = 12
        @(negedge clk);
        a1 = 4'd7; b1 = 4'd5; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        lat = 0;
        while (done1 !== 1'b1 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check("d1.latency", 32'(lat), 32'd1);
        check("d1.sum", 32'(sum1), 32'h2);
        check("d1.cout", 32'(cout1), 32'd1);
        check("d1.err", 32'(err1), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
